uart_cmd_engine: RTL
====================

Name: uart_cmd_engine

Overview:
- Host-command stage sitting directly downstream of the UART's RX FIFO read port and upstream of its TX FIFO write port.
- Pops received bytes and parses fixed-format register-access frames.
- Executes single-cycle reads/writes on a simple register bus, then pushes ACK/NAK response bytes back into the UART for transmission.

Parameters:
- dbit, 8, byte width (matches UART data width).
- aw, 8, register bus address width; aw <= dbit, taken from addr byte LSBs.
- hdr, 8'hA5, frame header byte.
- ack, 8'h06, acknowledge byte.
- nak, 8'h15, negative-acknowledge byte.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rx_empty  in  1  UART RX FIFO empty.
- rx_data  in  dbit  UART RX FIFO head byte; valid whenever rx_empty=0.
- rx_rd  out  1  one-cycle pop of RX FIFO head.
- tx_full  in  1  UART TX FIFO full.
- tx_wr  out  1  one-cycle push into TX FIFO.
- tx_data  out  dbit  byte pushed with tx_wr.
- bus_wr  out  1  register write strobe, one cycle.
- bus_rd  out  1  register read strobe, one cycle.
- bus_addr  out  aw  register address.
- bus_wdata  out  dbit  write data.
- bus_rdata  in  dbit  read data; valid the cycle after bus_rd.
- busy  out  1  high in every state except S_HDR.
- err_cnt  out  8  NAK count, saturates at 8'hFF.

Behaviour:
- Reset (synchronous): state=S_HDR; all outputs 0 (rx_rd, tx_wr, tx_data, bus_wr, bus_rd, bus_addr, bus_wdata, busy, err_cnt). Reset mid-frame discards the partial frame and emits no response.
- Byte fetch: in a fetch state with rx_empty=0, assert rx_rd for one cycle, register rx_data, and advance. Never assert rx_rd in two consecutive cycles; each fetch state spans at least 2 cycles. When rx_empty=1, hold with no timeout.
- Frame format: hdr, cmd, addr, [data if cmd=write], [csum if CMD_CHECKSUM_EN]. cmd 8'h01 = write, 8'h02 = read.
- S_HDR: fetch a byte. If it equals hdr, go to S_CMD. Otherwise discard silently (resync) and stay; no NAK.
- S_CMD: fetch cmd. 01/02 go to S_ADDR. Any other value goes to S_RESP with nak; the remaining bytes are then hunted as non-header.
- S_ADDR: fetch byte; bus_addr <= byte[aw-1:0]. Write goes to S_DATA. Read goes to S_CSUM, or S_EXEC when the feature is off.
- S_DATA: fetch byte into bus_wdata. Then S_CSUM, or S_EXEC when the feature is off.
- S_EXEC:
  - Write: bus_wr=1 for one cycle, then S_RESP with ack.
  - Read: bus_rd=1 for one cycle, then S_RDCAP, which registers bus_rdata, then S_RESP with ack followed by the data byte.
- S_RESP: push queued bytes in order, one per cycle. tx_wr=1 only when tx_full=0; otherwise hold tx_data stable and wait. tx_wr is never asserted while tx_full=1. After the last byte, return to S_HDR.
- Each NAK increments err_cnt, saturating at 255.
- Latency, full-rate FIFOs: last request byte popped to first response push is 2 cycles for write and 3 cycles for read.
- bus_addr and bus_wdata retain their values after the frame completes.

Optional Feature:
- Macro: CMD_CHECKSUM_EN.
- Defined: adds state S_CSUM, which fetches a checksum byte equal to cmd ^ addr ^ data (data only for writes).
  - Match: proceed to S_EXEC.
  - Mismatch: S_RESP with nak; no bus strobe; err_cnt increments.
- Undefined: no checksum byte; S_CSUM is absent. ADDR (read) and DATA (write) go straight to S_EXEC.

Test Plan:
- Write: feed A5 01 10 3C (plus csum 2D when enabled) -> single bus_wr with addr 8'h10 and wdata 8'h3C; TX receives 06.
- Read: feed A5 02 20 (plus csum 22), bus_rdata=8'h5A -> one bus_rd at 8'h20; TX receives 06, 5A; busy drops afterwards.
- Resync and bad cmd: feed 00 FF A5 07 -> no response for 00 FF; one NAK 15; err_cnt=1; no bus strobes.
- Backpressure: read frame with tx_full held high 10 cycles -> tx_wr stays 0 and tx_data is stable; 06 then data pushed once full clears, no duplicates.
- Checksum (macro on): A5 01 10 3C with csum 00 -> TX 15; no bus_wr; err_cnt increments. Err_cnt saturation: 256 NAKs -> err_cnt=FF.
- Reset mid-frame: assert rst after A5 01 -> all outputs 0 next cycle; a following full write frame executes normally.

Source files
------------

// File: rtl/uart_cmd_engine.sv
`timescale 1ns/1ps
// uart_cmd_engine
// Host-command stage between a UART RX FIFO read port and a TX FIFO write
// port. Parses frames  hdr, cmd, addr, [data], [csum]  and performs one
// register-bus write (cmd 01) or read (cmd 02). Replies with ack (plus the
// read byte) or nak.
//
// Build option: define CMD_CHECKSUM_EN to require a trailing checksum byte
// (cmd ^ addr ^ data, data only for writes). Without it no checksum is read.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   rx_empty/rx_data/rx_rd   RX FIFO status, head byte, one-cycle pop
//   tx_full/tx_wr/tx_data    TX FIFO status, one-cycle push, pushed byte
//   bus_wr/bus_rd            one-cycle register write/read strobes
//   bus_addr/bus_wdata       register address and write data (held after frame)
//   bus_rdata                read data, valid the cycle after bus_rd
//   busy                     high whenever not hunting for a header
//   err_cnt                  number of naks sent, saturating at 8'hFF
module uart_cmd_engine #(
    parameter int unsigned     dbit = 8,
    parameter int unsigned     aw   = 8,
    parameter logic [dbit-1:0] hdr  = dbit'(8'hA5),
    parameter logic [dbit-1:0] ack  = dbit'(8'h06),
    parameter logic [dbit-1:0] nak  = dbit'(8'h15)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx_empty,
    input  logic [dbit-1:0] rx_data,
    output logic            rx_rd,
    input  logic            tx_full,
    output logic            tx_wr,
    output logic [dbit-1:0] tx_data,
    output logic            bus_wr,
    output logic            bus_rd,
    output logic [aw-1:0]   bus_addr,
    output logic [dbit-1:0] bus_wdata,
    input  logic [dbit-1:0] bus_rdata,
    output logic            busy,
    output logic [7:0]      err_cnt
);

    localparam logic [dbit-1:0] cmd_wr = dbit'(8'h01);
    localparam logic [dbit-1:0] cmd_rd = dbit'(8'h02);

    typedef enum logic [2:0] {
        S_HDR, S_CMD, S_ADDR, S_DATA, S_EXEC, S_RDCAP, S_RESP
`ifdef CMD_CHECKSUM_EN
        , S_CSUM
`endif
    } state_t;

    state_t          state;
    logic            got;        // second cycle of a fetch: rx_byte holds the popped byte
    logic [dbit-1:0] rx_byte;
    logic            is_wr;
    logic            resp_pend;  // a response byte is waiting in tx_data
    logic            two;        // the read-data byte still follows the current one
    logic [dbit-1:0] resp1;
    logic            fetch;
    logic [7:0]      err_inc;
`ifdef CMD_CHECKSUM_EN
    logic [dbit-1:0] csum;
`endif

    // States that pop a request byte
    always_comb begin
        fetch = 1'b0;
        case (state)
            S_HDR, S_CMD, S_ADDR, S_DATA: fetch = 1'b1;
`ifdef CMD_CHECKSUM_EN
            S_CSUM: fetch = 1'b1;
`endif
            default: fetch = 1'b0;
        endcase
    end

    assign err_inc = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;

    // Push is qualified by the live tx_full so a byte never lands on a full FIFO
    assign tx_wr = resp_pend & ~tx_full;

    // Frame parser / executor
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_HDR;
            got       <= 1'b0;
            rx_byte   <= '0;
            is_wr     <= 1'b0;
            resp_pend <= 1'b0;
            two       <= 1'b0;
            resp1     <= '0;
            rx_rd     <= 1'b0;
            tx_data   <= '0;
            bus_wr    <= 1'b0;
            bus_rd    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            busy      <= 1'b0;
            err_cnt   <= '0;
`ifdef CMD_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            rx_rd  <= 1'b0;
            bus_wr <= 1'b0;
            bus_rd <= 1'b0;
            got    <= 1'b0;

            // First cycle of a fetch: pop the head and capture it
            if (fetch && !got && !rx_empty) begin
                rx_rd   <= 1'b1;
                rx_byte <= rx_data;
                got     <= 1'b1;
            end

            case (state)
                S_HDR: begin
                    if (got && rx_byte == hdr) begin
                        state <= S_CMD;
                        busy  <= 1'b1;
                    end
                end
                S_CMD: begin
                    if (got) begin
                        if (rx_byte == cmd_wr || rx_byte == cmd_rd) begin
                            is_wr <= (rx_byte == cmd_wr);
                            state <= S_ADDR;
`ifdef CMD_CHECKSUM_EN
                            csum  <= rx_byte;
`endif
                        end else begin
                            tx_data   <= nak;
                            two       <= 1'b0;
                            resp_pend <= 1'b1;
                            err_cnt   <= err_inc;
                            state     <= S_RESP;
                        end
                    end
                end
                S_ADDR: begin
                    if (got) begin
                        bus_addr <= rx_byte[aw-1:0];
`ifdef CMD_CHECKSUM_EN
                        csum     <= csum ^ rx_byte;
                        state    <= is_wr ? S_DATA : S_CSUM;
`else
                        if (is_wr) begin
                            state <= S_DATA;
                        end else begin
                            bus_rd <= 1'b1;
                            state  <= S_EXEC;
                        end
`endif
                    end
                end
                S_DATA: begin
                    if (got) begin
                        bus_wdata <= rx_byte;
`ifdef CMD_CHECKSUM_EN
                        csum      <= csum ^ rx_byte;
                        state     <= S_CSUM;
`else
                        bus_wr    <= 1'b1;
                        state     <= S_EXEC;
`endif
                    end
                end
`ifdef CMD_CHECKSUM_EN
                S_CSUM: begin
                    if (got) begin
                        if (rx_byte == csum) begin
                            bus_wr <= is_wr;
                            bus_rd <= ~is_wr;
                            state  <= S_EXEC;
                        end else begin
                            tx_data   <= nak;
                            two       <= 1'b0;
                            resp_pend <= 1'b1;
                            err_cnt   <= err_inc;
                            state     <= S_RESP;
                        end
                    end
                end
`endif
                // Strobe is high during this state; writes respond at once
                S_EXEC: begin
                    if (is_wr) begin
                        tx_data   <= ack;
                        two       <= 1'b0;
                        resp_pend <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        state <= S_RDCAP;
                    end
                end
                S_RDCAP: begin
                    tx_data   <= ack;
                    resp1     <= bus_rdata;
                    two       <= 1'b1;
                    resp_pend <= 1'b1;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    if (resp_pend && !tx_full) begin
                        if (two) begin
                            tx_data <= resp1;
                            two     <= 1'b0;
                        end else begin
                            resp_pend <= 1'b0;
                            busy      <= 1'b0;
                            state     <= S_HDR;
                        end
                    end
                end
                default: state <= S_HDR;
            endcase
        end
    end

endmodule
